alu_execute_unit: RTL
=====================

Name: alu_execute_unit

Overview:
- Consumer side of the ALU operand interface. Accepts DATA0/DATA1 plus decoded FUNCT3/FUNCT1 qualifiers from ALU operand select, executes RV32I integer ops, and returns a registered RESULT over a valid/ready handshake.
- Logic and arithmetic ops complete in one cycle. Shifts are iterative: SHIFT_STEP bit positions per cycle, so the barrel shifter is removed from the execute path.
- Sits between operand select and writeback/address generation.

Parameters:
- N, 32, datapath width.
- SHIFT_STEP, 1, bit positions shifted per SHIFT cycle. Legal values: 1, 2, 4, 8.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ALU_EN  input  1  operand valid; an op is accepted when ALU_EN & READY.
- DATA0  input  N  operand A.
- DATA1  input  N  operand B; DATA1[$clog2(N)-1:0] is the shift amount.
- FUNCT3  input  3  operation select.
- FUNCT1  input  1  instruction bit 30: SUB for reg-reg 000, SRA for 101.
- OP_IMM  input  1  immediate-form op; suppresses SUB on FUNCT3=000.
- FORCE_ADD  input  1  forces ADD regardless of FUNCT3/FUNCT1 (load/store/LUI/AUIPC).
- FLUSH  input  1  synchronous abort of the in-flight op.
- READY  output  1  unit can accept an op this cycle.
- RESULT  output  N  registered result.
- RESULT_VALID  output  1  RESULT holds a completed result.
- RESULT_READY  input  1  consumer takes RESULT this cycle.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, RESULT=0, RESULT_VALID=0, shift counter=0, READY=1.
- States:
  - IDLE: waiting for an op.
  - SHIFT: iterative shift in progress.
  - DONE: RESULT_VALID=1, held until taken.
- READY = (state==IDLE) | (state==DONE & RESULT_READY). It is combinational from state and RESULT_READY; it never depends on ALU_EN.
- Operation decode at acceptance:
  - FORCE_ADD=1: ADD, ignoring FUNCT3 and FUNCT1.
  - 000: SUB if FUNCT1 & ~OP_IMM, else ADD. Arithmetic is modulo 2^N; overflow is ignored.
  - 001: SLL.
  - 010: SLT, signed, result {N-1 zeros, lt}.
  - 011: SLTU, unsigned.
  - 100: XOR. 110: OR. 111: AND.
  - 101: SRA if FUNCT1, else SRL. SRA fills with DATA0[N-1].
- Non-shift op accepted at edge k: state=DONE, RESULT and RESULT_VALID visible after edge k. Latency is 1 cycle.
- Shift op with amount s:
  - s=0: behaves as a non-shift op; RESULT=DATA0 at latency 1.
  - s>0: edge k loads accumulator=DATA0, remaining=s, state=SHIFT. Each following edge shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
  - When remaining reaches 0: RESULT=accumulator, state=DONE. Valid appears ceil(s/SHIFT_STEP)+1 edges after acceptance.
- Shift kind, fill bit and shift amount are captured at acceptance. Input changes during SHIFT have no effect.
- DONE: RESULT and RESULT_VALID are stable until RESULT_READY=1.
  - On the handshake edge with no new op: RESULT_VALID→0, state→IDLE, RESULT retains its value.
  - Handshake and ALU_EN in the same cycle: the new op is accepted on that edge; the old result is consumed. Back-to-back non-shift ops sustain 1 result/cycle with RESULT_VALID continuously high.
- ALU_EN while READY=0: ignored, no state change. Upstream holds the op.
- FLUSH=1 (highest priority over all synchronous events): next edge forces IDLE, RESULT_VALID=0, remaining=0. ALU_EN in the same cycle is not accepted. RESULT keeps its old value.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values; no partial result is emitted.
- RESULT_VALID never deasserts without a handshake, FLUSH or reset.

Test Plan:
- Reset then ADD: DATA0=0x00000005, DATA1=0xFFFFFFFE, FUNCT3=000, FUNCT1=0 → RESULT=0x00000003, RESULT_VALID one edge after acceptance. Repeat with FUNCT1=1, OP_IMM=0 → 0x00000007. Repeat with FUNCT1=1, OP_IMM=1 → 0x00000003.
- SLT vs SLTU: DATA0=0xFFFFFFFF, DATA1=0x00000001 → SLT RESULT=1, SLTU RESULT=0. FORCE_ADD=1 with FUNCT3=100 → RESULT=0x00000000 (add, not xor).
- SRA, SHIFT_STEP=1: DATA0=0x80000000, DATA1[4:0]=4, FUNCT3=101, FUNCT1=1 → READY low 5 cycles, RESULT=0xF8000000. The same op with FUNCT1=0 → 0x08000000. Shift amount 0 → RESULT=DATA0 at latency 1.
- Backpressure: hold RESULT_READY=0 for 3 cycles after valid → RESULT stable, READY=0, ALU_EN ignored. Then 4 back-to-back XORs with RESULT_READY=1 → 4 consecutive valid cycles with correct values.
- FLUSH: issue SLL by 31, assert FLUSH on cycle 3 of SHIFT → next cycle IDLE, READY=1, RESULT_VALID never asserted. A subsequent AND, 0xF0F0F0F0 & 0xFF00FF00, yields 0xF000F000.
- Async reset: drop RST_N mid-SHIFT between clock edges → RESULT_VALID=0, RESULT=0 and READY=1 immediately. After release, normal operation resumes.

Source files
------------

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: RV32I execute stage with single-cycle logic/arith ops and an iterative shifter behind a valid/ready result handshake.
module alu_execute_unit #(
  parameter int N          = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         ALU_EN,
  input  logic [N-1:0] DATA0,
  input  logic [N-1:0] DATA1,
  input  logic [2:0]   FUNCT3,
  input  logic         FUNCT1,
  input  logic         OP_IMM,
  input  logic         FORCE_ADD,
  input  logic         FLUSH,
  output logic         READY,
  output logic [N-1:0] RESULT,
  output logic         RESULT_VALID,
  input  logic         RESULT_READY
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d, result_q, result_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          left_q, left_d, fill_q, fill_d;
  logic          accept, is_shift, is_sub;
  logic [SW-1:0] s_amt, amt;
  logic [N-1:0]  op_res, shl, shr;

  assign READY        = (state_q == IDLE) | ((state_q == DONE) & RESULT_READY);
  assign RESULT       = result_q;
  assign RESULT_VALID = state_q == DONE;
  assign accept       = ALU_EN & READY;
  assign s_amt        = DATA1[SW-1:0];

  always_comb begin
    is_shift = ~FORCE_ADD & (FUNCT3[1:0] == 2'b01);
    is_sub   = ~FORCE_ADD & FUNCT1 & ~OP_IMM & (FUNCT3 == 3'b000);
    // Shift opcodes only reach this mux with a zero amount, so they pass DATA0 through
    op_res   = (FORCE_ADD | (FUNCT3 == 3'b000)) ? (is_sub ? DATA0 - DATA1 : DATA0 + DATA1) :
               (FUNCT3 == 3'b010) ? {{(N-1){1'b0}}, $signed(DATA0) < $signed(DATA1)} :
               (FUNCT3 == 3'b011) ? {{(N-1){1'b0}}, DATA0 < DATA1} :
               (FUNCT3 == 3'b100) ? DATA0 ^ DATA1 :
               (FUNCT3 == 3'b110) ? DATA0 | DATA1 :
               (FUNCT3 == 3'b111) ? DATA0 & DATA1 : DATA0;
    amt      = (rem_q < STEP) ? rem_q : STEP;
    shl      = acc_q << amt;
    shr      = (acc_q >> amt) | (~({N{1'b1}} >> amt) & {N{fill_q}});
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    rem_d    = rem_q;
    left_d   = left_q;
    fill_d   = fill_q;
    if (FLUSH) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (accept) begin
      if (is_shift & (s_amt != '0)) begin
        state_d = SHIFT;
        acc_d   = DATA0;
        rem_d   = s_amt;
        left_d  = ~FUNCT3[2];
        fill_d  = FUNCT3[2] & FUNCT1 & DATA0[N-1];
      end else begin
        state_d  = DONE;
        result_d = op_res;
      end
    end else if (state_q == SHIFT) begin
      if (rem_q == '0) begin
        state_d  = DONE;
        result_d = acc_q;
      end else begin
        acc_d = left_q ? shl : shr;
        rem_d = rem_q - amt;
      end
    end else if ((state_q == DONE) & RESULT_READY) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      fill_q   <= fill_d;
    end
  end
endmodule
